// File: rtl/vme_bus_pkg.sv
// Shared definitions for the VME bus-ownership logic: requester state encoding,
// release-mode selectors and the default bus-grant timeout.
package vme_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_OWN     = 3'd2,
        ST_PARKED  = 3'd3,
        ST_RELEASE = 3'd4
    } vme_state_e;

    localparam int RELEASE_RWD        = 32'sd0;
    localparam int RELEASE_ROR        = 32'sd1;
    localparam int BG_TIMEOUT_DEFAULT = 32'sd16;

endpackage

// File: rtl/vme_requester.sv
// VME requester: acquires the backplane over BR/BG/BBSY at a fixed level, holds it
// for the local master and releases it in release-when-done or release-on-request mode.
module vme_requester
    import vme_bus_pkg::*;
#(
    parameter int BR_LEVEL     = 1,
    parameter int RELEASE_MODE = RELEASE_RWD,
    parameter int BG_TIMEOUT   = BG_TIMEOUT_DEFAULT,
    parameter int BBSY_MIN     = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic       xfer_busy,
    output logic       grant,
    output logic       timeout_err,
    input  logic [3:0] vme_bgin_n,
    output logic [3:0] vme_bgout_n,
    input  logic [3:0] vme_br_in_n,
    output logic [3:0] vme_br_n,
    input  logic       vme_bbsy_in_n,
    output logic       vme_bbsy_n,
    input  logic       vme_bclr_n
);

    localparam int TW = $clog2(BG_TIMEOUT + 1);
    localparam int CW = $clog2(BBSY_MIN + 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1'b1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(BG_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(BBSY_MIN);
    localparam logic [3:0]    L_MASK    = 4'b0001 << BR_LEVEL;
    localparam logic          ROR_MODE  = (RELEASE_MODE == RELEASE_ROR);

    vme_state_e    state_q, state_d;
    logic          bg_seen_q, bg_seen_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_q, grant_d;
    logic          timeout_err_q, timeout_err_d;
    logic [3:0]    br_n_q, br_n_d;
    logic          bbsy_n_q, bbsy_n_d;
    logic          bg_low_s;
    logic          other_req_s;

    assign bg_low_s    = ~vme_bgin_n[BR_LEVEL];
    assign other_req_s = ~&vme_br_in_n;

    // Our own grant level is only passed down the chain while idle (or held in reset).
    assign vme_bgout_n = vme_bgin_n | (((state_q == ST_IDLE) || !reset_n) ? 4'b0000 : L_MASK);

    // Next-state and next-output computation for the ownership state machine.
    always_comb begin
        state_d       = state_q;
        bg_seen_d     = bg_seen_q;
        timer_d       = timer_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        timeout_err_d = 1'b0;
        br_n_d        = br_n_q;
        bbsy_n_d      = bbsy_n_q;
        case (state_q)
            ST_IDLE: begin
                grant_d   = 1'b0;
                br_n_d    = 4'hF;
                bbsy_n_d  = 1'b1;
                bg_seen_d = 1'b0;
                // A grant still low from a previous tenure must drop before we re-request.
                if (req && vme_bgin_n[BR_LEVEL]) begin
                    state_d  = ST_REQUEST;
                    br_n_d   = ~L_MASK;
                    timer_d  = TIMER_ONE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (timer_q == TIMER_MAX) begin
                    state_d   = ST_IDLE;
                    br_n_d    = 4'hF;
                    bg_seen_d = 1'b0;
                end else if (bg_seen_q && bg_low_s && vme_bbsy_in_n) begin
                    state_d   = ST_OWN;
                    br_n_d    = 4'hF;
                    bbsy_n_d  = 1'b0;
                    grant_d   = 1'b1;
                    cnt_d     = CNT_ONE;
                    bg_seen_d = 1'b0;
                end else begin
                    bg_seen_d     = bg_low_s;
                    timer_d       = timer_q + TIMER_ONE;
                    timeout_err_d = (timer_q == (TIMER_MAX - TIMER_ONE));
                end
            end
            ST_OWN: begin
                grant_d  = 1'b1;
                bbsy_n_d = 1'b0;
                br_n_d   = 4'hF;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
                if ((cnt_q == CNT_MAX) && !xfer_busy) begin
                    if (!vme_bclr_n || (!req && (!ROR_MODE || other_req_s))) begin
                        state_d  = ST_RELEASE;
                        grant_d  = 1'b0;
                        bbsy_n_d = 1'b1;
                    end else if (!req) begin
                        state_d  = ST_PARKED;
                        grant_d  = 1'b0;
                    end else begin
                        state_d  = ST_OWN;
                    end
                end else begin
                    state_d = ST_OWN;
                end
            end
            ST_PARKED: begin
                grant_d  = 1'b0;
                bbsy_n_d = 1'b0;
                br_n_d   = 4'hF;
                if (req) begin
                    state_d = ST_OWN;
                    grant_d = 1'b1;
                    cnt_d   = CNT_ONE;
                end else if (other_req_s || !vme_bclr_n) begin
                    state_d  = ST_RELEASE;
                    bbsy_n_d = 1'b1;
                end else begin
                    state_d = ST_PARKED;
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                grant_d  = 1'b0;
                bbsy_n_d = 1'b1;
                br_n_d   = 4'hF;
            end
            default: begin
                state_d   = ST_IDLE;
                grant_d   = 1'b0;
                bbsy_n_d  = 1'b1;
                br_n_d    = 4'hF;
                bg_seen_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            bg_seen_q     <= 1'b0;
            timer_q       <= '0;
            cnt_q         <= '0;
            grant_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            br_n_q        <= 4'hF;
            bbsy_n_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            bg_seen_q     <= bg_seen_d;
            timer_q       <= timer_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            timeout_err_q <= timeout_err_d;
            br_n_q        <= br_n_d;
            bbsy_n_q      <= bbsy_n_d;
        end
    end

    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;
    assign vme_br_n    = br_n_q;
    assign vme_bbsy_n  = bbsy_n_q;

endmodule

// File: tb/tb_vme_requester.sv
// Directed bench for vme_requester: one RWD instance and one ROR instance at level 1
// share the same stimulus; each scenario task checks the instance it targets.
module tb_vme_requester;

    logic       clk;
    logic       reset_n;
    logic       req;
    logic       xfer_busy;
    logic [3:0] bgin_n;
    logic [3:0] br_in_n;
    logic       bbsy_in_n;
    logic       bclr_n;

    logic       grant_a, tmo_a, bbsy_n_a;
    logic [3:0] bgout_a, br_n_a;
    logic       grant_b, tmo_b, bbsy_n_b;
    logic [3:0] bgout_b, br_n_b;

    int errors = 0;
    int checks = 0;

    vme_requester #(.BR_LEVEL(1), .RELEASE_MODE(0), .BG_TIMEOUT(16), .BBSY_MIN(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .req(req), .xfer_busy(xfer_busy),
        .grant(grant_a), .timeout_err(tmo_a),
        .vme_bgin_n(bgin_n), .vme_bgout_n(bgout_a),
        .vme_br_in_n(br_in_n), .vme_br_n(br_n_a),
        .vme_bbsy_in_n(bbsy_in_n), .vme_bbsy_n(bbsy_n_a), .vme_bclr_n(bclr_n)
    );

    vme_requester #(.BR_LEVEL(1), .RELEASE_MODE(1), .BG_TIMEOUT(16), .BBSY_MIN(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req), .xfer_busy(xfer_busy),
        .grant(grant_b), .timeout_err(tmo_b),
        .vme_bgin_n(bgin_n), .vme_bgout_n(bgout_b),
        .vme_br_in_n(br_in_n), .vme_br_n(br_n_b),
        .vme_bbsy_in_n(bbsy_in_n), .vme_bbsy_n(bbsy_n_b), .vme_bclr_n(bclr_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req = 1'b0; xfer_busy = 1'b0; bgin_n = 4'hF;
        br_in_n = 4'hF; bbsy_in_n = 1'b1; bclr_n = 1'b1;
        step(2);
        reset_n = 1'b1;
    endtask

    // Request and receive a clean two-sample grant; leaves both instances in OWN cycle 1.
    task automatic acquire();
        req = 1'b1;
        step(1);
        bgin_n = 4'b1101;
        step(2);
        bgin_n = 4'hF;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = 1'b0; xfer_busy = 1'b0; bgin_n = 4'b1101;
        br_in_n = 4'hF; bbsy_in_n = 1'b1; bclr_n = 1'b1;
        step(1);
        checks++; if (grant_a !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b exp 0", grant_a); end
        checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b exp 0", tmo_a); end
        checks++; if (br_n_a !== 4'hF) begin errors++; $display("FAIL reset_br: got %b exp 1111", br_n_a); end
        checks++; if (bbsy_n_a !== 1'b1) begin errors++; $display("FAIL reset_bbsy: got %b exp 1", bbsy_n_a); end
        checks++; if (bgout_a !== 4'b1101) begin errors++; $display("FAIL reset_bgout: got %b exp 1101", bgout_a); end
        bgin_n = 4'hF;
        step(1);
        reset_n = 1'b1;
    endtask

    task automatic test_rwd_basic();
        do_reset();
        req = 1'b1;
        step(1);
        checks++; if (br_n_a !== 4'b1101) begin errors++; $display("FAIL rwd_br: got %b exp 1101", br_n_a); end
        bgin_n = 4'b1101;
        #1;
        checks++; if (bgout_a !== 4'b1111) begin errors++; $display("FAIL rwd_bgout_req: got %b exp 1111", bgout_a); end
        step(1);
        checks++; if ({bbsy_n_a, grant_a} !== 2'b10) begin errors++; $display("FAIL rwd_filter: got bbsy=%b grant=%b exp 1/0", bbsy_n_a, grant_a); end
        step(1);
        checks++; if ({bbsy_n_a, grant_a} !== 2'b01) begin errors++; $display("FAIL rwd_own: got bbsy=%b grant=%b exp 0/1", bbsy_n_a, grant_a); end
        checks++; if (br_n_a !== 4'hF) begin errors++; $display("FAIL rwd_br_own: got %b exp 1111", br_n_a); end
        checks++; if (bgout_a !== 4'b1111) begin errors++; $display("FAIL rwd_bgout_own: got %b exp 1111", bgout_a); end
        step(1);
        bgin_n = 4'hF; req = 1'b0;
        step(1);
        checks++; if ({bbsy_n_a, grant_a} !== 2'b10) begin errors++; $display("FAIL rwd_release: got bbsy=%b grant=%b exp 1/0", bbsy_n_a, grant_a); end
        step(1);
        checks++; if (br_n_a !== 4'hF) begin errors++; $display("FAIL rwd_idle_br: got %b exp 1111", br_n_a); end
    endtask

    task automatic test_bbsy_min();
        do_reset();
        acquire();
        req = 1'b0;
        step(1);
        checks++; if (bbsy_n_a !== 1'b0) begin errors++; $display("FAIL bbsy_min_hold: got %b exp 0", bbsy_n_a); end
        step(1);
        checks++; if (bbsy_n_a !== 1'b1) begin errors++; $display("FAIL bbsy_min_rel: got %b exp 1", bbsy_n_a); end
    endtask

    task automatic test_passthrough_glitch();
        do_reset();
        bgin_n = 4'b0111;
        #1;
        checks++; if (bgout_a !== 4'b0111) begin errors++; $display("FAIL pass_idle: got %b exp 0111", bgout_a); end
        bgin_n = 4'b1101; req = 1'b1;
        step(1);
        checks++; if (br_n_a !== 4'hF) begin errors++; $display("FAIL stale_bg: got %b exp 1111", br_n_a); end
        bgin_n = 4'hF;
        step(1);
        checks++; if (br_n_a !== 4'b1101) begin errors++; $display("FAIL req_after_stale: got %b exp 1101", br_n_a); end
        bgin_n = 4'b1101;
        step(1);
        bgin_n = 4'hF;
        step(2);
        checks++; if ({bbsy_n_a, grant_a} !== 2'b10) begin errors++; $display("FAIL glitch_own: got bbsy=%b grant=%b exp 1/0", bbsy_n_a, grant_a); end
        checks++; if (br_n_a !== 4'b1101) begin errors++; $display("FAIL glitch_br: got %b exp 1101", br_n_a); end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 1'b1;
        step(15);
        checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b exp 0", tmo_a); end
        step(1);
        checks++; if (tmo_a !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b exp 1", tmo_a); end
        checks++; if (br_n_a !== 4'b1101) begin errors++; $display("FAIL tmo_br_held: got %b exp 1101", br_n_a); end
        step(1);
        checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL tmo_one_cycle: got %b exp 0", tmo_a); end
        checks++; if (br_n_a !== 4'hF) begin errors++; $display("FAIL tmo_br_rel: got %b exp 1111", br_n_a); end
        step(1);
        checks++; if (br_n_a !== 4'b1101) begin errors++; $display("FAIL tmo_rereq: got %b exp 1101", br_n_a); end
        req = 1'b0;
    endtask

    task automatic test_ror_parking();
        do_reset();
        acquire();
        req = 1'b0;
        step(1);
        checks++; if ({bbsy_n_b, grant_b} !== 2'b01) begin errors++; $display("FAIL ror_min: got bbsy=%b grant=%b exp 0/1", bbsy_n_b, grant_b); end
        step(3);
        checks++; if ({bbsy_n_b, grant_b} !== 2'b00) begin errors++; $display("FAIL ror_parked: got bbsy=%b grant=%b exp 0/0", bbsy_n_b, grant_b); end
        req = 1'b1;
        step(1);
        checks++; if ({bbsy_n_b, grant_b} !== 2'b01) begin errors++; $display("FAIL ror_regrant: got bbsy=%b grant=%b exp 0/1", bbsy_n_b, grant_b); end
        checks++; if (br_n_b !== 4'hF) begin errors++; $display("FAIL ror_no_br: got %b exp 1111", br_n_b); end
        req = 1'b0;
        step(2);
        checks++; if ({bbsy_n_b, grant_b} !== 2'b00) begin errors++; $display("FAIL ror_reparked: got bbsy=%b grant=%b exp 0/0", bbsy_n_b, grant_b); end
        br_in_n = 4'b1110;
        step(1);
        checks++; if ({bbsy_n_b, grant_b} !== 2'b10) begin errors++; $display("FAIL ror_release: got bbsy=%b grant=%b exp 1/0", bbsy_n_b, grant_b); end
        br_in_n = 4'hF;
    endtask

    task automatic test_bclr_busy();
        do_reset();
        acquire();
        xfer_busy = 1'b1; bclr_n = 1'b0;
        step(4);
        checks++; if ({bbsy_n_a, grant_a} !== 2'b01) begin errors++; $display("FAIL bclr_hold_a: got bbsy=%b grant=%b exp 0/1", bbsy_n_a, grant_a); end
        checks++; if ({bbsy_n_b, grant_b} !== 2'b01) begin errors++; $display("FAIL bclr_hold_b: got bbsy=%b grant=%b exp 0/1", bbsy_n_b, grant_b); end
        xfer_busy = 1'b0;
        step(1);
        checks++; if ({bbsy_n_a, grant_a} !== 2'b10) begin errors++; $display("FAIL bclr_rel_a: got bbsy=%b grant=%b exp 1/0", bbsy_n_a, grant_a); end
        checks++; if ({bbsy_n_b, grant_b} !== 2'b10) begin errors++; $display("FAIL bclr_rel_b: got bbsy=%b grant=%b exp 1/0", bbsy_n_b, grant_b); end
        bclr_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        acquire();
        req = 1'b0;
        step(2);
        checks++; if (bbsy_n_a !== 1'b1) begin errors++; $display("FAIL b2b_release: got %b exp 1", bbsy_n_a); end
        req = 1'b1;
        step(1);
        checks++; if (br_n_a !== 4'hF) begin errors++; $display("FAIL b2b_gap: got %b exp 1111", br_n_a); end
        step(1);
        checks++; if (br_n_a !== 4'b1101) begin errors++; $display("FAIL b2b_rereq: got %b exp 1101", br_n_a); end
        req = 1'b0;
    endtask

    task automatic test_reset_mid_tenure();
        do_reset();
        acquire();
        checks++; if (grant_a !== 1'b1) begin errors++; $display("FAIL mid_pre_grant: got %b exp 1", grant_a); end
        reset_n = 1'b0;
        step(1);
        checks++; if ({bbsy_n_a, grant_a} !== 2'b10) begin errors++; $display("FAIL mid_reset: got bbsy=%b grant=%b exp 1/0", bbsy_n_a, grant_a); end
        checks++; if (br_n_a !== 4'hF) begin errors++; $display("FAIL mid_reset_br: got %b exp 1111", br_n_a); end
        reset_n = 1'b1; req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rwd_basic();
        test_bbsy_min();
        test_passthrough_glitch();
        test_timeout();
        test_ror_parking();
        test_bclr_busy();
        test_back_to_back();
        test_reset_mid_tenure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vme_requester.md
# vme_requester

Requester-side bus-ownership controller for one VME master port. It acquires the backplane from the system arbiter at a fixed BR level over the BR/BG/BBSY handshake and passes the BG daisy chain through when idle. It holds the bus for the local master, then releases it in release-when-done (RWD) or release-on-request (ROR) mode, and honours BCLR. It sits between the local master engine and the backplane buffers, one instance per board.

## Interface
- `BR_LEVEL`, 1: request level, 0–3.
- `RELEASE_MODE`, 0: 0 = RWD, 1 = ROR (bus parking).
- `BG_TIMEOUT`, 16: clk cycles allowed in REQUEST with no filtered BG before abort.
- `BBSY_MIN`, 2: minimum clk cycles BBSY is driven low per tenure; must be ≥ 1.

Ports:
- `clk` in 1: system clock. All `vme_*` inputs are synchronized to `clk` upstream.
- `reset_n` in 1: reset, synchronous, active-low.
- `req` in 1: local master wants the bus. Level signal.
- `xfer_busy` in 1: local transfer in progress. Release is never started while it is high.
- `grant` out 1: bus owned by this board. Registered.
- `timeout_err` out 1: one-cycle pulse on BG timeout.
- `vme_bgin_n` in 4: bus grant daisy-chain inputs.
- `vme_bgout_n` out 4: bus grant daisy-chain outputs.
- `vme_br_in_n` in 4: sensed backplane BR lines.
- `vme_br_n` out 4: BR drive; 1 = released.
- `vme_bbsy_in_n` in 1: sensed BBSY.
- `vme_bbsy_n` out 1: BBSY drive; 1 = released.
- `vme_bclr_n` in 1: bus clear from the arbiter.

## Operation
Daisy chain:
- For levels other than L (= `BR_LEVEL`), `vme_bgout_n[i] = vme_bgin_n[i]`, combinational.
- For level L, `vme_bgout_n[L] = vme_bgin_n[L]` only in IDLE; it is 1 in every other state.

States:
- **IDLE**: all outputs released. Go to REQUEST when `req`=1 and `vme_bgin_n[L]`=1 (a stale BG must drop first).
- **REQUEST**: drive `vme_br_n[L]`=0 and load the timer.
  - BG filter: `vme_bgin_n[L]`=0 sampled on 2 consecutive cycles and `vme_bbsy_in_n`=1 → OWN.
  - A single-cycle BG low clears the filter and stays in REQUEST.
  - Timer reaches `BG_TIMEOUT` → pulse `timeout_err`, release BR, go to IDLE.
  - If `req` drops while in REQUEST, acquisition still completes and then releases immediately; BR is never withdrawn without a grant.
- **OWN**: `vme_bbsy_n`=0 and `vme_br_n[L]`=1 on entry; `grant`=1. Load the BBSY_MIN counter.
  - Leave only when the counter has expired and `xfer_busy`=0.
  - RWD: release when `req`=0 or `vme_bclr_n`=0.
  - ROR: release when (`req`=0 and any `vme_br_in_n`=0) or `vme_bclr_n`=0.
  - ROR with `req`=0 and no other request: stay in **PARKED**.
- **PARKED** (ROR only): `vme_bbsy_n`=0, `grant`=0.
  - `req`=1 → OWN directly; no arbitration, `grant` rises on the next edge.
  - Any `vme_br_in_n`=0 or `vme_bclr_n`=0 → RELEASE.
- **RELEASE**: `vme_bbsy_n`=1, `grant`=0 for one cycle, then IDLE.
- Simultaneous BCLR and `xfer_busy`=1: hold the bus until `xfer_busy` falls, then release on the next edge.

## Timing
- Reset, on the first edge with `reset_n`=0: state IDLE; `grant`=0, `timeout_err`=0, `vme_br_n`=4'hF, `vme_bbsy_n`=1.
  - During reset `vme_bgout_n[L]` passes `vme_bgin_n[L]`.
  - Reset mid-tenure releases BBSY and BR on that same edge.
- Latency from `req`=1 in IDLE to `vme_br_n[L]`=0: 1 cycle.
- Latency from first BG-low sample to `vme_bbsy_n`=0 and `grant`=1: 2 cycles.
- BBSY low time ≥ `BBSY_MIN` cycles, even if `req` drops immediately.
- Release latency, from qualifying condition to `vme_bbsy_n`=1: 1 cycle. Next request possible 2 cycles later, provided BG-in is high.
- Timer width is `$clog2(BG_TIMEOUT+1)` and saturates; it never wraps. The BBSY_MIN counter is sized the same way.

## Structure
- Shared package `vme_bus_pkg`: state encoding (IDLE, REQUEST, OWN, PARKED, RELEASE), `RELEASE_RWD`/`RELEASE_ROR` constants, default `BG_TIMEOUT`.
- No sub-module. The BG filter, timer and BBSY_MIN counter are inline, in one state-machine process plus the combinational daisy-chain assign.

## Test plan
- **RWD basic** (L=1): `req`=1; arbiter drives `vme_bgin_n`=4'b1101 for 3 cycles → `vme_br_n`=4'b1101 one cycle after `req`; `vme_bbsy_n`=0 and `grant`=1 two cycles after first BG; `vme_bgout_n[1]`=1 throughout. `req`=0 → BBSY released 1 cycle later (after ≥2 cycles low).
- **Pass-through/glitch**: IDLE, `vme_bgin_n`=4'b0111 → `vme_bgout_n`=4'b0111 same cycle. In REQUEST, a one-cycle BG pulse → no BBSY, still requesting.
- **Timeout**: `req`=1, BG never arrives → `timeout_err` pulses at cycle 16 of REQUEST; `vme_br_n`=4'hF next cycle; state IDLE.
- **ROR parking**: `RELEASE_MODE`=1, own then `req`=0 → BBSY stays low, `grant`=0. `req`=1 → `grant`=1 next edge with no BR. Then `vme_br_in_n`=4'b1110 with `req`=0 → BBSY released in 1 cycle.
- **BCLR with busy**: OWN, `xfer_busy`=1, `vme_bclr_n`=0 → BBSY held. `xfer_busy`=0 → BBSY released next edge, `grant`=0.
- **Reset mid-tenure**: `reset_n`=0 while in OWN → next edge `vme_bbsy_n`=1, `grant`=0, `vme_br_n`=4'hF.
